edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
- Collects rising-edge events from N single-bit control lines (buttons and strobes) and queues one pending event per line.
- Round-robin arbitration serialises the pending events onto a single valid/ready event port consumed by the downstream command decoder.
- Each line has its own two-flop rising-edge detector; an event is one clock of `ff1 & ~ff2`.
- Sits between the input synchronisers and the control FSM.

Parameters:
- N, 4, number of input lines (2..16).
- IDX_W, 2, width of the event index; must satisfy 2^IDX_W >= N.
- DB_CYCLES, 8, debounce stability window in clocks; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in  input  N  already-synchronised input lines.
- evt_valid  output  1  event offered.
- evt_idx  output  IDX_W  index of the offered line.
- evt_ready  input  1  consumer accepts the event.
- pending  output  N  per-line pending flags.
- ovf  output  N  sticky per-line overflow flags.
- ovf_clr  input  N  clears the corresponding ovf bits; single cycle per bit.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: when rst_n=0 at a clk rising edge, all state clears.
  - Cleared state: ff1, ff2, pending, ovf, evt_valid=0, evt_idx=0. last_grant=N-1, so line 0 has first priority.
  - Asserting reset mid-offer drops the offered event and all pending events.
- Edge detect per line:
  - ff1[i]<=in[i] and ff2[i]<=ff1[i].
  - edge[i]=ff1[i]&~ff2[i], high for exactly one cycle.
  - in[i] rising before clock edge k gives edge[i] high during the cycle after edge k.
- Pending:
  - On edge[i], pending[i] is set at the next clock.
  - If pending[i] is already 1 and line i is not being accepted that cycle, the event is dropped and ovf[i] is set.
  - ovf[i] clears when ovf_clr[i]=1. If set and clear coincide, set wins.
- FSM with states IDLE and OFFER:
  - IDLE: if pending!=0, select the first set bit searching from last_grant+1 upward, wrapping modulo N. Register evt_idx, set evt_valid=1, go to OFFER.
  - OFFER: evt_valid and evt_idx hold stable until evt_ready=1.
  - On handshake (evt_valid&evt_ready): clear pending[evt_idx], last_grant<=evt_idx, evt_valid<=0, go to IDLE.
  - New edge on the accepted line in the handshake cycle: pending stays 1 and is counted as a new event; no ovf.
- Timing:
  - Latency from edge[i] to evt_valid is 2 cycles when IDLE with nothing pending.
  - Maximum throughput is one event per 2 cycles.
- Handshake rules:
  - evt_ready while evt_valid=0 is ignored.
  - evt_idx must not change while evt_valid=1.
- The pending output is a direct register view.

Optional Feature:
- Macro: EDGE_ARB_DEBOUNCE_EN.
- When defined:
  - Each line has a counter of width ceil(log2(DB_CYCLES+1)) and a stable register db[i], reset to 0.
  - ff1 samples db instead of in.
  - db[i] takes in[i] only after in[i] has differed from db[i] for DB_CYCLES consecutive clocks. Any cycle with in[i]==db[i] reloads the counter to 0.
  - Glitches shorter than DB_CYCLES produce no event.
  - Edge-to-evt_valid latency grows by DB_CYCLES.
- When undefined: no counters, and ff1 samples in directly.

Test Plan:
- Reset and single event:
  - Stimulus: N=4; hold rst_n=0 for 3 clocks; release; raise in=4'b0010 and hold.
  - Response: exactly one event with evt_idx=1; evt_valid rises 2 cycles after the first edge; with evt_ready=1 it drops next cycle. pending=0, ovf=0, and no further events while in stays high.
- Round-robin:
  - Stimulus: pulse in=4'b1111 once with evt_ready=1 throughout.
  - Response: evt_idx sequence 0,1,2,3, one event per 2 cycles, then evt_valid=0.
  - Stimulus: after last_grant=1, pulse lines 0 and 3.
  - Response: order 3 then 0.
- Backpressure and stability:
  - Stimulus: evt_ready=0 for 10 cycles with pending line 2.
  - Response: evt_valid=1 and evt_idx=2 stable for all 10 cycles; accepted on the first cycle evt_ready=1.
- Overflow:
  - Stimulus: with evt_ready=0, give line 0 two rising edges 4 cycles apart.
  - Response: ovf=4'b0001, pending[0]=1, and only one event is delivered.
  - Stimulus: pulse ovf_clr[0].
  - Response: ovf=0.
- Coincident edge and accept:
  - Stimulus: edge on line 3 in the same cycle the handshake accepts line 3.
  - Response: pending[3] remains 1, ovf[3]=0, and a second event with idx 3 follows.
- Mid-offer reset, and debounce (macro defined, DB_CYCLES=8):
  - Stimulus: assert rst_n=0 during OFFER.
  - Response: next cycle evt_valid=0 and pending=0.
  - Stimulus: a 5-cycle high pulse on line 1.
  - Response: no event.
  - Stimulus: a 12-cycle high pulse on line 1.
  - Response: one event with idx 1, evt_valid rising 10 cycles after in rises.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-line rising-edge capture, round-robin onto one valid/ready port.
// Optional input debounce compiled in with `define EDGE_ARB_DEBOUNCE_EN.
module edge_event_arbiter #(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int DB_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  input  logic             evt_ready,
  output logic [N-1:0]     pending,
  output logic [N-1:0]     ovf,
  input  logic [N-1:0]     ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     src;
  logic [N-1:0]     ff1_q, ff2_q;
  logic [N-1:0]     rise;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     ovf_q, ovf_d;
  logic [N-1:0]     clr_vec;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             acc;

`ifdef EDGE_ARB_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  db_q, db_d;

  // A line only moves once it has disagreed with db for DB_CYCLES clocks.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (in[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) db_d[i] = in[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign src = db_q;
`else
  assign src = in;
`endif

  assign rise    = ff1_q & ~ff2_q;
  assign acc     = valid_q & evt_ready;
  assign clr_vec = acc ? (N'(1) << idx_q) : '0;

  // Set beats clear, so an edge on the line being accepted re-arms it.
  assign pend_d = (pend_q & ~clr_vec) | rise;
  assign ovf_d  = (ovf_q & ~ovf_clr) | (rise & pend_q & ~clr_vec);

  always_comb begin
    int j;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(last_q) + k;
      if (j >= N) j = j - N;
      if (!found && pend_q[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OFFER;
          valid_d = 1'b1;
          idx_d   = pick;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ff1_q   <= '0;
      ff2_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N - 1);
    end else begin
      state_q <= state_d;
      ff1_q   <= src;
      ff2_q   <= ff1_q;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_idx   = idx_q;
  assign pending   = pend_q;
  assign ovf       = ovf_q;

endmodule
